bet_wear_leveler: RTL and testbench
===================================

# bet_wear_leveler

Parametrised static wear-leveling controller built on a Block Erase Table (BET): one flag bit per flash block records whether that block has been erased in the current interval. The block counts erases (`e_cnt`) and distinct flagged blocks (`f_cnt`). When `e_cnt >= T*f_cnt`, it scans the BET for an unflagged (cold) block and hands that block's address to the garbage collector over a valid/ready handshake. It sits between the erase path of the flash translation layer and the garbage-collection engine.

## Interface
- `BLK_AW`, 12, block address width; `NUM_BLK = 2**BLK_AW`
- `CNT_W`, 32, width of `e_cnt` and `f_cnt`; `CNT_W` must be greater than `BLK_AW`
- `T_W`, 8, width of the threshold constant
- `T`, 100, leveling threshold (ratio `e_cnt/f_cnt`); range 1..2**T_W-1
- `clk_50`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wl_en`  in  1  leveling enable; when 0, counting continues but no scan starts
- `erase_valid`  in  1  erase event offered
- `erase_addr`  in  BLK_AW  erased block
- `erase_ready`  out  1  block accepts erase event
- `gc_valid`  out  1  cold-block request to garbage collector
- `gc_addr`  out  BLK_AW  cold block address
- `gc_ready`  in  1  garbage collector accepts request
- `busy`  out  1  high in any state except IDLE
- `e_cnt_o`, `f_cnt_o`  out  CNT_W  current counters (status)

## Operation
- FSM states: CLEAR, IDLE, ERS_RD, ERS_WR, CHECK, SCAN_RD, SCAN_EVAL, GC_REQ.
- CLEAR: write 0 to BET addresses 0..NUM_BLK-1, one address per cycle. Zero `e_cnt`, `f_cnt` and `f_index` on entry. Go to IDLE after address NUM_BLK-1 is written.
- IDLE: `erase_ready=1`. On `erase_valid&&erase_ready`, latch `erase_addr` and go to ERS_RD.
- ERS_RD: read the BET at the latched address.
- ERS_WR:
  - `e_cnt` increments, saturating at all-ones.
  - If the flag is 0: write 1 and increment `f_cnt`.
  - If the flag is 1: no write.
  - Next state CHECK.
- CHECK, in priority order:
  - `f_cnt==NUM_BLK`: go to CLEAR (new interval).
  - Else `wl_en && f_cnt!=0 && e_cnt >= T*f_cnt`: go to SCAN_RD. The product is computed at CNT_W+T_W bits; no divider is used.
  - Else: go to IDLE.
- SCAN_RD: read the BET at `f_index`.
- SCAN_EVAL:
  - If the flag is 0: load `gc_addr<=f_index` and go to GC_REQ.
  - In both cases `f_index` increments, wrapping from NUM_BLK-1 to 0.
  - If the flag is 1: go back to SCAN_RD.
  - Termination is guaranteed because CHECK enters a scan only when `f_cnt<NUM_BLK`. A scan visits at most NUM_BLK addresses.
- GC_REQ:
  - Hold `gc_valid=1` and `gc_addr` stable until `gc_ready`.
  - On the cycle `gc_valid&&gc_ready` is high, go to IDLE; `gc_valid` is 0 the next cycle.
  - `gc_ready` has no effect outside GC_REQ.
- `f_index` persists across scans within an interval, so a scan resumes where the previous one stopped.
- `erase_ready` is 0 in every state except IDLE. Erase events are never dropped; the producer must hold them.
- `wl_en` falling during a scan does not abort it. The current scan completes through GC_REQ.

## Timing
- Reset values:
  - `erase_ready=0`, `gc_valid=0`, `gc_addr=0`, `busy=1`, counters 0.
  - State is CLEAR, so `erase_ready` first rises NUM_BLK cycles after reset release.
- BET read latency: 1 cycle (synchronous read).
- Erase event with no scan: 3 cycles (ERS_RD, ERS_WR, CHECK). `erase_ready` is high again on the 4th cycle after acceptance.
- Scan: 2 cycles per BET entry visited. `gc_valid` rises 2k cycles after CHECK, where k is the number of entries examined.
- Interval rollover costs NUM_BLK cycles, with `erase_ready=0`.
- Reset asserted mid-operation (any state) returns the block to CLEAR immediately. A pending `gc_valid` drops asynchronously.

## Structure
- Package `bet_pkg`:
  - FSM state enum `bet_state_t`.
  - Threshold-product width helper `T_PROD_W = CNT_W+T_W`.
- Sub-module `bet_flag_ram`: single-port, 1-bit wide, NUM_BLK deep. Synchronous read, write-enable, address BLK_AW; no reset on contents (CLEAR initialises it).
- `bet_wear_leveler` contains the FSM, counters, `f_index` and the handshake registers.

## Test plan
- BLK_AW=4, T=2. Reset release, then erase block 3 on cycle 16 -> `erase_ready` is 0 for cycles 0-15; after the erase, `e_cnt_o=1`, `f_cnt_o=1`; no `gc_valid`.
- BLK_AW=4, T=2. Erase block 3 twice -> `e_cnt=2`, `f_cnt=1`, `2>=2` triggers a scan. Flags 0..2 are 0, so `gc_valid` rises with `gc_addr=0`. Hold `gc_ready=0` for 5 cycles: `gc_valid` and `gc_addr` stay stable. Assert `gc_ready`: `gc_valid` drops next cycle and `f_index=1`.
- BLK_AW=4, T=2. Set flags 0..5 so that `f_index` starts at 0, then trigger leveling -> `gc_addr=6`, `gc_valid` rises 14 cycles after CHECK.
- BLK_AW=4. Erase all 16 distinct blocks -> CLEAR entered on the 16th; all flags 0 afterwards; counters 0; `erase_ready` returns after 16 cycles.
- `wl_en=0`, T=1, erase one block 10 times -> `e_cnt=10`, no `gc_valid`. Raise `wl_en` and erase once more -> scan starts and returns the first unflagged block.
- Assert `rst` low during GC_REQ -> `gc_valid=0` asynchronously; after release, CLEAR runs and counters read 0.

Source files
------------

// File: rtl/bet_pkg.sv
// Shared types and helpers for the block-erase-table wear leveler.
package bet_pkg;

    // Controller states; CLEAR is the reset state and starts every interval.
    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StErsRd,
        StErsWr,
        StCheck,
        StScanRd,
        StScanEval,
        StGcReq
    } bet_state_t;

    // Width of T*f_cnt, wide enough that the threshold product never overflows.
    function automatic int unsigned t_prod_w(input int unsigned cnt_w, input int unsigned t_w);
        return cnt_w + t_w;
    endfunction

endpackage

// File: rtl/bet_flag_ram.sv
// One flag bit per flash block; synchronous read, contents are not reset.
module bet_flag_ram #(
    parameter int unsigned BLK_AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BLK_AW-1:0] addr,
    input  logic              wdata,
    output logic              rdata
);

    localparam int unsigned NUM_BLK = 2 ** BLK_AW;

    logic mem [NUM_BLK];

    // Single port: write when enabled, read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bet_wear_leveler.sv
// Static wear leveler: counts erases and distinct erased blocks, and when the
// erase/flag ratio reaches T it hands the next cold block to garbage collection.
module bet_wear_leveler
    import bet_pkg::*;
#(
    parameter int unsigned BLK_AW = 12,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned T_W    = 8,
    parameter int unsigned T      = 100
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              wl_en,
    input  logic              erase_valid,
    input  logic [BLK_AW-1:0] erase_addr,
    output logic              erase_ready,
    output logic              gc_valid,
    output logic [BLK_AW-1:0] gc_addr,
    input  logic              gc_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  e_cnt_o,
    output logic [CNT_W-1:0]  f_cnt_o
);

    localparam int unsigned NUM_BLK  = 2 ** BLK_AW;
    localparam int unsigned T_PROD_W = t_prod_w(CNT_W, T_W);

    bet_state_t        state_q, state_d;
    logic [BLK_AW-1:0] clr_addr_q;
    logic [BLK_AW-1:0] ers_addr_q;
    logic [BLK_AW-1:0] f_index_q;
    logic [CNT_W-1:0]  e_cnt_q;
    logic [CNT_W-1:0]  f_cnt_q;

    logic              ram_we;
    logic              ram_wdata;
    logic [BLK_AW-1:0] ram_addr;
    logic              flag_rd;

    logic              f_full;
    logic              lvl_due;

    // Every block flagged means the interval is over; f_cnt is wider than BLK_AW.
    assign f_full  = (f_cnt_q == CNT_W'(NUM_BLK));
    assign lvl_due = (T_PROD_W'(e_cnt_q) >= (T_PROD_W'(T) * T_PROD_W'(f_cnt_q)));

    bet_flag_ram #(
        .BLK_AW (BLK_AW)
    ) u_flag_ram (
        .clk   (clk_50),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (flag_rd)
    );

    // State register.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear:    if (&clr_addr_q) state_d = StIdle;
            StIdle:     if (erase_valid) state_d = StErsRd;
            StErsRd:    state_d = StErsWr;
            StErsWr:    state_d = StCheck;
            StCheck: begin
                if (f_full) begin
                    state_d = StClear;
                end else if (wl_en && (f_cnt_q != '0) && lvl_due) begin
                    state_d = StScanRd;
                end else begin
                    state_d = StIdle;
                end
            end
            StScanRd:   state_d = StScanEval;
            // A scan is only entered with at least one unflagged block, so it terminates.
            StScanEval: state_d = flag_rd ? StScanRd : StGcReq;
            StGcReq:    if (gc_ready) state_d = StIdle;
            default:    state_d = StClear;
        endcase
    end

    // Outputs and flag-RAM port control, decoded from the current state.
    always_comb begin
        erase_ready = (state_q == StIdle);
        gc_valid    = (state_q == StGcReq);
        busy        = (state_q != StIdle);
        ram_we      = 1'b0;
        ram_wdata   = 1'b0;
        ram_addr    = ers_addr_q;
        unique case (state_q)
            StClear: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
            end
            StErsWr: begin
                ram_we    = ~flag_rd;
                ram_wdata = 1'b1;
            end
            StScanRd: ram_addr = f_index_q;
            default:  ram_addr = ers_addr_q;
        endcase
    end

    // Counters, scan pointer and latched addresses.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            clr_addr_q <= '0;
            ers_addr_q <= '0;
            f_index_q  <= '0;
            e_cnt_q    <= '0;
            f_cnt_q    <= '0;
            gc_addr    <= '0;
        end else begin
            // clr_addr wraps back to 0 on the last CLEAR cycle, ready for the next interval.
            if (state_q == StClear) begin
                clr_addr_q <= clr_addr_q + BLK_AW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (erase_valid) begin
                        ers_addr_q <= erase_addr;
                    end
                end
                StErsWr: begin
                    if (!(&e_cnt_q)) begin
                        e_cnt_q <= e_cnt_q + CNT_W'(1);
                    end
                    if (!flag_rd) begin
                        f_cnt_q <= f_cnt_q + CNT_W'(1);
                    end
                end
                StCheck: begin
                    if (f_full) begin
                        e_cnt_q   <= '0;
                        f_cnt_q   <= '0;
                        f_index_q <= '0;
                    end
                end
                StScanEval: begin
                    f_index_q <= f_index_q + BLK_AW'(1);
                    if (!flag_rd) begin
                        gc_addr <= f_index_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign e_cnt_o = e_cnt_q;
    assign f_cnt_o = f_cnt_q;

endmodule

// File: tb/tb_bet_wear_leveler.sv
// Bench for bet_wear_leveler: directed scenarios plus random erase traffic,
// checked against a transaction-level model of the erase table.
module tb_bet_wear_leveler;

    localparam int unsigned BLK_AW  = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned T_W     = 8;
    localparam int unsigned T       = 2;
    localparam int unsigned NUM_BLK = 16;

    logic              clk_50 = 1'b0;
    logic              rst;
    logic              wl_en;
    logic              erase_valid;
    logic [BLK_AW-1:0] erase_addr;
    logic              erase_ready;
    logic              gc_valid;
    logic [BLK_AW-1:0] gc_addr;
    logic              gc_ready;
    logic              busy;
    logic [CNT_W-1:0]  e_cnt_o;
    logic [CNT_W-1:0]  f_cnt_o;

    bet_wear_leveler #(
        .BLK_AW (BLK_AW),
        .CNT_W  (CNT_W),
        .T_W    (T_W),
        .T      (T)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .wl_en       (wl_en),
        .erase_valid (erase_valid),
        .erase_addr  (erase_addr),
        .erase_ready (erase_ready),
        .gc_valid    (gc_valid),
        .gc_addr     (gc_addr),
        .gc_ready    (gc_ready),
        .busy        (busy),
        .e_cnt_o     (e_cnt_o),
        .f_cnt_o     (f_cnt_o)
    );

    always #5 clk_50 = ~clk_50;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the erase table as a plain array plus the two counters.
    bit     m_flag [NUM_BLK];
    longint m_e;
    longint m_f;
    int     m_fi;
    bit     m_aborted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NUM_BLK; i++) m_flag[i] = 1'b0;
        m_e  = 0;
        m_f  = 0;
        m_fi = 0;
    endtask

    // Called just after a rising edge with rst low: release it and time the clear pass.
    task automatic release_and_clear;
        rst = 1'b1;
        model_reset();
        for (int i = 1; i <= NUM_BLK; i++) begin
            tick();
            if (i < NUM_BLK) check("clear_ready_low", erase_ready, 1'b0);
            else             check("clear_ready_high", erase_ready, 1'b1);
        end
        check("clear_e_cnt", e_cnt_o, 0);
        check("clear_f_cnt", f_cnt_o, 0);
    endtask

    // One erase transaction; hold < 0 picks a random gc_ready delay.
    task automatic do_erase(input logic [BLK_AW-1:0] a, input int hold, input bit abort);
        int  n;
        int  kind;
        int  lat;
        int  k;
        int  idx;
        int  d;
        logic [BLK_AW-1:0] exp_addr;
        n = 0;
        while (!erase_ready && n < 300) begin
            tick();
            n++;
        end
        check("erase_ready_wait", erase_ready, 1'b1);
        erase_valid = 1'b1;
        erase_addr  = a;
        tick();
        erase_valid = 1'b0;
        erase_addr  = $urandom_range(0, NUM_BLK - 1);

        // Model the outcome of this erase.
        exp_addr = '0;
        if (m_e != 64'hFFFF_FFFF) m_e++;
        if (!m_flag[a]) begin
            m_flag[a] = 1'b1;
            m_f++;
        end
        if (m_f == NUM_BLK) begin
            kind = 2;
            lat  = 3 + NUM_BLK;
            model_reset();
        end else if (wl_en && m_f != 0 && m_e >= T * m_f) begin
            kind = 1;
            k    = 0;
            idx  = m_fi;
            for (int s = 0; s < NUM_BLK; s++) begin
                k++;
                if (!m_flag[idx]) break;
                idx = (idx + 1) % NUM_BLK;
            end
            exp_addr = idx[BLK_AW-1:0];
            m_fi     = (idx + 1) % NUM_BLK;
            lat      = 3 + 2 * k;
        end else begin
            kind = 0;
            lat  = 3;
        end

        n = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            n = c;
            if (gc_valid || erase_ready) break;
        end
        check("latency", n, lat);
        check("gc_valid", gc_valid, kind == 1);
        check("erase_ready", erase_ready, kind != 1);
        check("busy", busy, kind == 1);
        check("e_cnt", e_cnt_o, m_e);
        check("f_cnt", f_cnt_o, m_f);

        if (kind == 1) begin
            check("gc_addr", gc_addr, exp_addr);
            if (abort) begin
                #2 rst = 1'b0;
                #1;
                check("rst_gc_valid", gc_valid, 1'b0);
                check("rst_busy", busy, 1'b1);
                check("rst_erase_ready", erase_ready, 1'b0);
                check("rst_gc_addr", gc_addr, 0);
                check("rst_e_cnt", e_cnt_o, 0);
                check("rst_f_cnt", f_cnt_o, 0);
                tick();
                release_and_clear();
                m_aborted = 1'b1;
                return;
            end
            d = (hold < 0) ? int'($urandom_range(0, 5)) : hold;
            for (int h = 0; h < d; h++) begin
                tick();
                check("gc_hold_valid", gc_valid, 1'b1);
                check("gc_hold_addr", gc_addr, exp_addr);
            end
            gc_ready = 1'b1;
            tick();
            gc_ready = 1'b0;
            check("gc_drop", gc_valid, 1'b0);
            check("gc_back_idle", erase_ready, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        wl_en       = 1'b1;
        erase_valid = 1'b0;
        erase_addr  = '0;
        gc_ready    = 1'b0;
        m_aborted   = 1'b0;
        tick();
        tick();
        check("reset_erase_ready", erase_ready, 1'b0);
        check("reset_gc_valid", gc_valid, 1'b0);
        check("reset_gc_addr", gc_addr, 0);
        check("reset_busy", busy, 1'b1);
        check("reset_e_cnt", e_cnt_o, 0);
        check("reset_f_cnt", f_cnt_o, 0);
        release_and_clear();

        // Single erase, then a repeat that trips the threshold (scan finds block 0).
        do_erase(4'd3, 0, 1'b0);
        do_erase(4'd3, 5, 1'b0);

        // Erase every remaining block once: the 16th distinct erase rolls the interval.
        for (int b = 0; b < NUM_BLK; b++) begin
            if (b != 3) do_erase(b[BLK_AW-1:0], -1, 1'b0);
        end

        // Fresh interval: flag 0..5, then re-erase block 0 until the scan finds block 6.
        for (int b = 0; b < 6; b++) do_erase(b[BLK_AW-1:0], -1, 1'b0);
        for (int r = 0; r < 6; r++) do_erase(4'd0, -1, 1'b0);

        // Leveling disabled: counting continues without scans, then re-enable.
        wl_en = 1'b0;
        for (int r = 0; r < 10; r++) do_erase(4'd9, -1, 1'b0);
        wl_en = 1'b1;
        do_erase(4'd9, -1, 1'b0);

        // Random traffic.
        for (int r = 0; r < 200; r++) begin
            wl_en = ($urandom_range(0, 3) != 0);
            do_erase($urandom_range(0, NUM_BLK - 1), -1, 1'b0);
        end

        // Reset while a request is pending.
        wl_en = 1'b1;
        for (int r = 0; r < 100 && !m_aborted; r++) do_erase(4'd0, -1, 1'b1);
        do_erase(4'd5, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
